// File: rtl/fifo_pair_rd_ctrl.sv
// fifo_pair_rd_ctrl: narrow-write / wide-read FWFT FIFO, one entry in, one {newer,older} pair out.
module fifo_pair_rd_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic                    wr,
  input  logic [DATA_WIDTH-1:0]   w_data,
  input  logic                    rd,
  output logic [2*DATA_WIDTH-1:0] r_data,
  output logic                    full,
  output logic                    empty,
  output logic [ADDR_WIDTH:0]     count,
  output logic                    ovf,
  output logic                    unf
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW = ADDR_WIDTH + 1;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_next;
  logic rd_acc, wr_acc;
  assign rd_acc = rd & ~empty;
  assign wr_acc = wr & (~full | rd_acc);
  assign count_next = count + CW'(wr_acc) - CW'({rd_acc, 1'b0});
  // rd_ptr is always even, so the partner entry sits at rd_ptr with bit 0 set
  assign r_data = {mem[{rd_ptr[ADDR_WIDTH-1:1], 1'b1}], mem[rd_ptr]};
  always_ff @(posedge clk)
    if (wr_acc && !flush) mem[wr_ptr] <= w_data;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      wr_ptr <= wr_acc ? wr_ptr + ADDR_WIDTH'(1) : wr_ptr;
      rd_ptr <= rd_acc ? rd_ptr + ADDR_WIDTH'(2) : rd_ptr;
      count  <= count_next;
      empty  <= count_next < CW'(2);
      full   <= count_next == CW'(DEPTH);
      ovf    <= wr & ~wr_acc;
      unf    <= rd & ~rd_acc;
    end
endmodule

// File: tb/tb_fifo_pair_rd_ctrl.sv
// tb_fifo_pair_rd_ctrl: directed vectors with hand-computed expectations for fifo_pair_rd_ctrl.
module tb_fifo_pair_rd_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic flush = 1'b0;
  logic wr = 1'b0;
  logic rd = 1'b0;
  logic [7:0] w_data = '0;
  logic [15:0] r_data;
  logic full, empty, ovf, unf;
  logic [3:0] count;
  int checks = 0;
  int errors = 0;
  fifo_pair_rd_ctrl #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .wr(wr), .w_data(w_data), .rd(rd),
    .r_data(r_data), .full(full), .empty(empty), .count(count), .ovf(ovf), .unf(unf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [7:0] d);
    wr = 1'b1;
    w_data = d;
    tick();
    wr = 1'b0;
  endtask
  task automatic pop_chk(input string tag, input logic [15:0] exp);
    chk(tag, r_data, exp);
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask
  initial begin
    #2 reset_n = 1'b0;
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_unf", unf, 0);
    reset_n = 1'b1;
    tick();
    push(8'h11);
    chk("t2_count1", count, 1);
    chk("t2_empty1", empty, 1);
    push(8'h22);
    chk("t2_empty2", empty, 0);
    chk("t2_rdata", r_data, 16'h2211);
    pop_chk("t2_pop", 16'h2211);
    chk("t2_count0", count, 0);
    chk("t2_empty0", empty, 1);
    for (int i = 1; i <= 8; i++) push(8'(i));
    chk("t3_full", full, 1);
    chk("t3_count", count, 8);
    push(8'h09);
    chk("t3_ovf", ovf, 1);
    chk("t3_count_hold", count, 8);
    tick();
    chk("t3_ovf_drop", ovf, 0);
    pop_chk("t3_rd0", 16'h0201);
    pop_chk("t3_rd1", 16'h0403);
    pop_chk("t3_rd2", 16'h0605);
    pop_chk("t3_rd3", 16'h0807);
    chk("t3_empty", empty, 1);
    for (int i = 1; i <= 6; i++) push(8'(i));
    pop_chk("t4_pre0", 16'h0201);
    pop_chk("t4_pre1", 16'h0403);
    for (int i = 7; i <= 12; i++) push(8'(i));
    chk("t4_count", count, 8);
    chk("t4_full", full, 1);
    pop_chk("t4_rd0", 16'h0605);
    pop_chk("t4_rd1", 16'h0807);
    pop_chk("t4_rd2", 16'h0A09);
    pop_chk("t4_rd3", 16'h0C0B);
    chk("t4_count0", count, 0);
    for (int i = 1; i <= 8; i++) push(8'(i));
    chk("t5_full", full, 1);
    chk("t5_rdata_full", r_data, 16'h0201);
    wr = 1'b1; w_data = 8'hAA; rd = 1'b1;
    tick();
    wr = 1'b0; rd = 1'b0;
    chk("t5_count7", count, 7);
    chk("t5_full_drop", full, 0);
    chk("t5_ovf0", ovf, 0);
    pop_chk("t5_rd1", 16'h0403);
    pop_chk("t5_rd2", 16'h0605);
    pop_chk("t5_rd3", 16'h0807);
    chk("t5_count1", count, 1);
    chk("t5_odd_empty", empty, 1);
    wr = 1'b1; w_data = 8'hBB; rd = 1'b1;
    tick();
    wr = 1'b0; rd = 1'b0;
    chk("t5_unf", unf, 1);
    chk("t5_count2", count, 2);
    chk("t5_empty0", empty, 0);
    chk("t5_pair", r_data, 16'hBBAA);
    pop_chk("t5_pop", 16'hBBAA);
    chk("t5_unf_drop", unf, 0);
    for (int i = 1; i <= 5; i++) push(8'(8'h20 + i));
    chk("t6_count5", count, 5);
    flush = 1'b1; wr = 1'b1; rd = 1'b1;
    tick();
    flush = 1'b0; wr = 1'b0; rd = 1'b0;
    chk("t6_fl_count", count, 0);
    chk("t6_fl_empty", empty, 1);
    chk("t6_fl_full", full, 0);
    chk("t6_fl_ovf", ovf, 0);
    chk("t6_fl_unf", unf, 0);
    push(8'h31);
    push(8'h32);
    push(8'h33);
    chk("t6_count3", count, 3);
    chk("t6_rdata", r_data, 16'h3231);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_arst_count", count, 0);
    chk("t6_arst_empty", empty, 1);
    reset_n = 1'b1;
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("t6_unf", unf, 1);
    chk("t6_count_end", count, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
